morra_cinese_param: RTL and testbench
=====================================

// Module: morra_cinese_param
// PURPOSE
// - Parametrised rock-paper-scissors match controller (FSMD): loads a match length, plays manches, tracks advantage, declares winner.
// - Successor to the fixed MorraCinese FSMD: thresholds are parameters, reset is explicit, outputs are registered, mid-game restart is defined.
// - Optional score/debug ports.
// - Sits between the players' move inputs and the result display/logging logic.
// PARAMETERS
// - MAX_BASE    4  max manches = MAX_BASE + {primo,secondo} captured on inizia (range MAX_BASE..MAX_BASE+15)
// - MIN_MANCHE  4  valid manches required before an early win can be declared
// - WIN_ADV     2  |advantage| that ends the match early (once count >= MIN_MANCHE)
// - localparams: CNT_W = $clog2(MAX_BASE+16); ADV_W = CNT_W+1 (two's complement)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      synchronous active-low reset
// - primo      in   2      player 1 move: 00 none/invalid, 01 sasso, 10 carta, 11 forbice
// - secondo    in   2      player 2 move, same encoding
// - inizia     in   1      start/restart match; {primo,secondo} is the length config that cycle
// - manche     out  2      last manche: 00 invalid/none, 01 primo won, 10 secondo won, 11 tie
// - partita    out  2      match: 00 running/idle, 01 primo won, 10 secondo won, 11 tie
// - vantaggio  out  ADV_W  signed advantage (MORRA_SCORE_EN only)
// - n_manche   out  CNT_W  valid manches played (MORRA_SCORE_EN only)
// BEHAVIOUR
// - All outputs registered; inputs sampled on rising edge N, result visible after edge N (one-cycle latency).
// - Reset (rst_n=0 at edge): state IDLE, manche=00, partita=00, count=0, adv=0, locks cleared, max=MAX_BASE. Overrides inizia.
// - FSM: IDLE -(inizia)-> GIOCO -(end condition)-> FINE -(inizia)-> GIOCO. inizia in any state, incl. mid-GIOCO, restarts.
// - inizia edge: max <= MAX_BASE + {primo,secondo}; count, adv, locks cleared; manche=00, partita=00; no manche played.
// - IDLE/FINE without inizia: moves ignored; manche=00; partita holds (00 in IDLE, final result in FINE) until inizia/reset.
// - GIOCO edge, inizia=0: manche is INVALID (manche=00, no state change) if either move is 00,
//   or a player repeats the move with which they won the previous valid manche (winner lock).
// - Valid manche: sasso>forbice, forbice>carta, carta>sasso; equal = tie.
//   - count += 1.
//   - primo win: adv += 1, lock primo's move, clear secondo lock.
//   - secondo win: adv -= 1, lock secondo's move, clear primo lock.
//   - tie: adv unchanged, both locks cleared.
// - End check on the same edge, using the updated count/adv:
//   - (count >= MIN_MANCHE && |adv| >= WIN_ADV) or count == max -> FINE.
//   - partita = 01 if adv>0, 10 if adv<0, 11 if adv==0.
//   - Early-win check has priority over the max check when both hold on the same edge; result identical.
// - No wrap: count never exceeds max (<= MAX_BASE+15), adv bounded by count; no saturation logic needed.
// CONFIGURATION
// - MORRA_SCORE_EN defined: vantaggio and n_manche ports exist, driven from the internal registers; reset/inizia value 0.
// - MORRA_SCORE_EN undefined: ports absent; internal behaviour and manche/partita timing identical.
// TESTING
// - Reset, then moves 01/11 without inizia -> manche=00, partita=00 (IDLE ignores).
// - inizia cfg 00,10 (max 6); manches 01/10, 11/10, 01/11, 11/11, 11/10, 01/10, 11/11
//   -> second manche invalid (secondo carta lock); partita=11 after last (adv 0, count 6).
// - inizia cfg 00,01 (max 5); 01/11, 10/01, 01/10, 10/11, 11/01 -> partita=10 after 5th (adv -1).
// - inizia cfg 11,11 (max 19); 01/11, 10/01, 11/10, 11/01, 01/10
//   -> 4th invalid (primo forbice lock); count3 adv3 no end; partita=01 on 5th (count 4, adv 2).
// - Mid-game inizia and mid-game rst_n=0 -> next cycle manche=00, partita=00, counters 0; rst_n beats inizia.
// - In FINE apply moves 01/11 -> manche=00, partita holds result; with MORRA_SCORE_EN check vantaggio/n_manche each step.

Source files
------------

// File: rtl/morra_cinese_param_if.sv
// Purpose : bundles the move inputs, start strobe and result outputs of the
//           rock-paper-scissors match controller into one port.
// Ports   : primo/secondo/inizia (to controller), manche/partita (from controller),
//           vantaggio/n_manche (from controller, only when MORRA_SCORE_EN is defined).
// Modports: master = players/driver side, slave = controller side.
interface morra_cinese_param_if #(
  parameter int MAX_BASE = 4
);
  logic [1:0] primo;
  logic [1:0] secondo;
  logic       inizia;
  logic [1:0] manche;
  logic [1:0] partita;
`ifdef MORRA_SCORE_EN
  localparam int CNT_W = $clog2(MAX_BASE + 16);
  localparam int ADV_W = CNT_W + 1;
  logic signed [ADV_W-1:0] vantaggio;
  logic [CNT_W-1:0]        n_manche;
`endif

  modport master (
    output primo, secondo, inizia,
`ifdef MORRA_SCORE_EN
    input  vantaggio, n_manche,
`endif
    input  manche, partita
  );

  modport slave (
    input  primo, secondo, inizia,
`ifdef MORRA_SCORE_EN
    output vantaggio, n_manche,
`endif
    output manche, partita
  );
endinterface

// File: rtl/morra_cinese_param.sv
// Purpose : parametrised rock-paper-scissors match controller (FSMD): loads a
//           match length on inizia, plays manches, tracks advantage and winner locks,
//           declares the match result. Optional macro MORRA_SCORE_EN exposes the
//           advantage (vantaggio) and valid-manche count (n_manche).
// Latency : one cycle; inputs sampled on rising edge, registered outputs valid after it.
// Ports   : clk, rst_n (synchronous, active-low), bus (slave modport of
//           morra_cinese_param_if: primo, secondo, inizia in; manche, partita out).
module morra_cinese_param #(
  parameter int MAX_BASE   = 4,
  parameter int MIN_MANCHE = 4,
  parameter int WIN_ADV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  morra_cinese_param_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_BASE + 16);
  localparam int ADV_W = CNT_W + 1;
  localparam logic signed [ADV_W-1:0] ADV_ONE = 1;

  localparam logic [1:0] SASSO   = 2'b01;
  localparam logic [1:0] CARTA   = 2'b10;
  localparam logic [1:0] FORBICE = 2'b11;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_PRIMO   = 2'b01;
  localparam logic [1:0] RES_SECONDO = 2'b10;
  localparam logic [1:0] RES_PARI    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GIOCO = 2'd1,
    S_FINE  = 2'd2
  } state_t;

  state_t                  r_state,   w_state_nxt;
  logic [1:0]              r_manche,  w_manche_nxt;
  logic [1:0]              r_partita, w_partita_nxt;
  logic [1:0]              r_lock_p,  w_lock_p_nxt;
  logic [1:0]              r_lock_s,  w_lock_s_nxt;
  logic [CNT_W-1:0]        r_cnt,     w_cnt_nxt;
  logic [CNT_W-1:0]        r_max,     w_max_nxt;
  logic signed [ADV_W-1:0] r_adv,     w_adv_nxt;

  logic                    w_tie;
  logic                    w_p_beats_s;
  logic                    w_invalid;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic signed [ADV_W-1:0] w_adv_play;
  logic [ADV_W-1:0]        w_adv_abs;
  logic                    w_end;
  logic [1:0]              w_partita_res;

  assign w_tie       = (bus.primo == bus.secondo);
  assign w_p_beats_s = (bus.primo == SASSO   && bus.secondo == FORBICE) ||
                       (bus.primo == FORBICE && bus.secondo == CARTA)   ||
                       (bus.primo == CARTA   && bus.secondo == SASSO);

  // A cleared lock is 00, and a 00 move is already invalid, so a plain equality
  // test against the lock covers both the locked and unlocked cases.
  assign w_invalid = (bus.primo == 2'b00) || (bus.secondo == 2'b00) ||
                     (bus.primo == r_lock_p) || (bus.secondo == r_lock_s);

  // Candidate values if this edge plays a valid manche; the end check uses them.
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_adv_play = w_tie       ? r_adv :
                      w_p_beats_s ? r_adv + ADV_ONE : r_adv - ADV_ONE;
  assign w_adv_abs  = w_adv_play[ADV_W-1] ? -w_adv_play : w_adv_play;

  // Early win and max-length end both yield the same result, so one OR suffices.
  assign w_end = ((w_cnt_inc >= CNT_W'(MIN_MANCHE)) && (w_adv_abs >= ADV_W'(WIN_ADV))) ||
                 (w_cnt_inc == r_max);

  assign w_partita_res = (w_adv_play == '0) ? RES_PARI    :
                         w_adv_play[ADV_W-1] ? RES_SECONDO : RES_PRIMO;

  always_comb begin
    w_state_nxt   = r_state;
    w_manche_nxt  = RES_NONE;
    w_partita_nxt = r_partita;
    w_lock_p_nxt  = r_lock_p;
    w_lock_s_nxt  = r_lock_s;
    w_cnt_nxt     = r_cnt;
    w_max_nxt     = r_max;
    w_adv_nxt     = r_adv;

    if (bus.inizia) begin
      // Start or restart from any state; the moves carry the length config.
      w_state_nxt   = S_GIOCO;
      w_max_nxt     = CNT_W'(MAX_BASE) + CNT_W'({bus.primo, bus.secondo});
      w_cnt_nxt     = '0;
      w_adv_nxt     = '0;
      w_lock_p_nxt  = 2'b00;
      w_lock_s_nxt  = 2'b00;
      w_partita_nxt = RES_NONE;
    end else begin
      case (r_state)
        S_GIOCO: begin
          if (!w_invalid) begin
            w_cnt_nxt = w_cnt_inc;
            w_adv_nxt = w_adv_play;
            if (w_tie) begin
              w_manche_nxt = RES_PARI;
              w_lock_p_nxt = 2'b00;
              w_lock_s_nxt = 2'b00;
            end else if (w_p_beats_s) begin
              w_manche_nxt = RES_PRIMO;
              w_lock_p_nxt = bus.primo;
              w_lock_s_nxt = 2'b00;
            end else begin
              w_manche_nxt = RES_SECONDO;
              w_lock_p_nxt = 2'b00;
              w_lock_s_nxt = bus.secondo;
            end
            if (w_end) begin
              w_state_nxt   = S_FINE;
              w_partita_nxt = w_partita_res;
            end
          end
        end
        default: begin
          // IDLE and FINE ignore moves; partita keeps its value.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_manche  <= RES_NONE;
      r_partita <= RES_NONE;
      r_lock_p  <= 2'b00;
      r_lock_s  <= 2'b00;
      r_cnt     <= '0;
      r_max     <= CNT_W'(MAX_BASE);
      r_adv     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_manche  <= w_manche_nxt;
      r_partita <= w_partita_nxt;
      r_lock_p  <= w_lock_p_nxt;
      r_lock_s  <= w_lock_s_nxt;
      r_cnt     <= w_cnt_nxt;
      r_max     <= w_max_nxt;
      r_adv     <= w_adv_nxt;
    end
  end

  assign bus.manche  = r_manche;
  assign bus.partita = r_partita;
`ifdef MORRA_SCORE_EN
  assign bus.vantaggio = r_adv;
  assign bus.n_manche  = r_cnt;
`endif

endmodule

// File: tb/tb_morra_cinese_param.sv
// Purpose : self-checking bench for morra_cinese_param; a driver applies directed and
//           random moves and pushes the expected outputs from a behavioural model into
//           a queue, an independent monitor pops and compares one cycle later.
module tb_morra_cinese_param;

  localparam int MAX_BASE   = 4;
  localparam int MIN_MANCHE = 4;
  localparam int WIN_ADV    = 2;

  typedef struct {
    int man;
    int part;
    int adv;
    int cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t q[$];
  int   checks;
  int   errors;

  // Reference model state: mode 0 idle, 1 playing, 2 finished.
  int m_mode, m_cnt, m_adv, m_max, m_lp, m_ls, m_part;

  morra_cinese_param_if #(.MAX_BASE(MAX_BASE)) bus ();

  morra_cinese_param #(
    .MAX_BASE  (MAX_BASE),
    .MIN_MANCHE(MIN_MANCHE),
    .WIN_ADV   (WIN_ADV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moves 1 sasso, 2 carta, 3 forbice form a cycle where each beats its predecessor.
  function automatic bit beats(int a, int b);
    return ((a - b + 3) % 3) == 1;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input bit rst, input bit ini, input int p, input int s, output exp_t e);
    int man;
    man = 0;
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_adv = 0; m_lp = 0; m_ls = 0; m_part = 0; m_max = MAX_BASE;
    end else if (ini) begin
      m_mode = 1; m_cnt = 0; m_adv = 0; m_lp = 0; m_ls = 0; m_part = 0;
      m_max  = MAX_BASE + p * 4 + s;
    end else if (m_mode == 1) begin
      if (p != 0 && s != 0 && !(m_lp != 0 && p == m_lp) && !(m_ls != 0 && s == m_ls)) begin
        m_cnt++;
        if (p == s) begin
          man = 3; m_lp = 0; m_ls = 0;
        end else if (beats(p, s)) begin
          man = 1; m_adv++; m_lp = p; m_ls = 0;
        end else begin
          man = 2; m_adv--; m_ls = s; m_lp = 0;
        end
        if ((m_cnt >= MIN_MANCHE && iabs(m_adv) >= WIN_ADV) || m_cnt == m_max) begin
          m_mode = 2;
          m_part = (m_adv > 0) ? 1 : (m_adv < 0) ? 2 : 3;
        end
      end
    end
    e.man  = man;
    e.part = m_part;
    e.adv  = m_adv;
    e.cnt  = m_cnt;
  endtask

  task automatic step(input bit rst, input bit ini, input int p, input int s);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    bus.inizia  = ini;
    bus.primo   = 2'(p);
    bus.secondo = 2'(s);
    model(rst, ini, p, s, e);
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // Monitor: the controller presents a result every cycle, one edge after stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("manche",  {30'b0, bus.manche},  32'(e.man));
        chk("partita", {30'b0, bus.partita}, 32'(e.part));
`ifdef MORRA_SCORE_EN
        chk("vantaggio", 32'($signed(bus.vantaggio)), 32'(e.adv));
        chk("n_manche",  32'(bus.n_manche),           32'(e.cnt));
`endif
      end
    end
  end

  initial begin
    int l1p[7] = '{1, 3, 1, 3, 3, 1, 3};
    int l1s[7] = '{2, 2, 3, 3, 2, 2, 3};
    int l2p[5] = '{1, 2, 1, 2, 3};
    int l2s[5] = '{3, 1, 2, 3, 1};
    int l3p[5] = '{1, 2, 3, 3, 1};
    int l3s[5] = '{3, 1, 2, 1, 2};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.inizia = 1'b0;
    bus.primo = 2'b00;
    bus.secondo = 2'b00;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // IDLE ignores moves.
    step(1, 0, 1, 3);
    step(1, 0, 1, 3);
    // Max 6, ends in a tie with one invalid manche from the winner lock.
    step(1, 1, 0, 2);
    foreach (l1p[i]) step(1, 0, l1p[i], l1s[i]);
    step(1, 0, 1, 3);
    step(1, 0, 1, 3);
    // Max 5, secondo wins on the last manche.
    step(1, 1, 0, 1);
    foreach (l2p[i]) step(1, 0, l2p[i], l2s[i]);
    step(1, 0, 1, 3);
    // Max 19, early win for primo once count reaches the minimum.
    step(1, 1, 3, 3);
    foreach (l3p[i]) step(1, 0, l3p[i], l3s[i]);
    step(1, 0, 1, 3);
    step(1, 0, 2, 1);
    // Mid-game restart, then reset asserted together with inizia.
    step(1, 1, 1, 1);
    step(1, 0, 1, 3);
    step(1, 0, 2, 1);
    step(1, 1, 0, 0);
    step(1, 0, 1, 3);
    step(0, 1, 2, 2);
    step(1, 0, 1, 3);

    for (int n = 0; n < 1500; n++) begin
      bit rst, ini;
      int p, s;
      rst = ($urandom_range(0, 199) != 0);
      ini = ($urandom_range(0, 24) == 0);
      p   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      s   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      step(rst, ini, p, s);
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
